// File: rtl/up_down_counter_mod.sv
// Up/down counter with runtime modulus, programmable step, wrap/saturate mode, load and event flags.
// Latency: count/pulses/stickies registered (1 cycle); at_max/at_zero combinational. No backpressure.
module up_down_counter_mod #(
    parameter int WIDTH     = 4,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             up_down,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] limit,
    input  logic             saturate,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_zero,
    output logic             ovf_pulse,
    output logic             unf_pulse,
    output logic             ovf_sticky,
    output logic             unf_sticky
);

    localparam logic [WIDTH-1:0] RST_COUNT = RESET_VAL[WIDTH-1:0];

    // One extra bit so limit = all-ones gives an exact modulus of 2**WIDTH.
    logic [WIDTH:0]   cnt_x;
    logic [WIDTH:0]   lim_x;
    logic [WIDTH:0]   mod_x;
    logic [WIDTH:0]   step_x;
    logic [WIDTH:0]   s_eff;
    logic [WIDTH:0]   sum_x;
    logic [WIDTH:0]   dn_wrap_x;
    logic [WIDTH:0]   up_wrap_x;
    logic [WIDTH:0]   dn_x;

    logic [WIDTH-1:0] count_nxt;
    logic             ovf_nxt;
    logic             unf_nxt;

    always_comb begin
        cnt_x     = {1'b0, count};
        lim_x     = {1'b0, limit};
        mod_x     = lim_x + 1'b1;
        step_x    = {1'b0, step};
        s_eff     = (step_x > mod_x) ? mod_x : step_x;
        sum_x     = cnt_x + s_eff;
        up_wrap_x = sum_x - mod_x;
        dn_x      = cnt_x - s_eff;
        dn_wrap_x = cnt_x + mod_x - s_eff;
    end

    always_comb begin
        count_nxt = count;
        ovf_nxt   = 1'b0;
        unf_nxt   = 1'b0;
        if (load) begin
            count_nxt = (load_val > limit) ? limit : load_val;
        end else if (en) begin
            if (count > limit) begin
                // Limit was lowered below the current count: restart from zero.
                count_nxt = '0;
                ovf_nxt   = 1'b1;
            end else if (up_down) begin
                if (sum_x > lim_x) begin
                    ovf_nxt   = 1'b1;
                    count_nxt = saturate ? limit : up_wrap_x[WIDTH-1:0];
                end else begin
                    count_nxt = sum_x[WIDTH-1:0];
                end
            end else begin
                if (cnt_x < s_eff) begin
                    unf_nxt   = 1'b1;
                    count_nxt = saturate ? '0 : dn_wrap_x[WIDTH-1:0];
                end else begin
                    count_nxt = dn_x[WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count      <= RST_COUNT;
            ovf_pulse  <= 1'b0;
            unf_pulse  <= 1'b0;
            ovf_sticky <= 1'b0;
            unf_sticky <= 1'b0;
        end else begin
            count      <= count_nxt;
            ovf_pulse  <= ovf_nxt;
            unf_pulse  <= unf_nxt;
            // A new event wins over a simultaneous clear.
            ovf_sticky <= (ovf_sticky & ~clr_flags) | ovf_nxt;
            unf_sticky <= (unf_sticky & ~clr_flags) | unf_nxt;
        end
    end

    assign at_max  = (count == limit);
    assign at_zero = (count == '0);

endmodule

// File: tb/tb_up_down_counter_mod.sv
// Bench for up_down_counter_mod (WIDTH=4): directed scenarios plus random traffic against an integer model.
module tb_up_down_counter_mod;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       en;
    logic       up_down;
    logic [3:0] step;
    logic [3:0] limit;
    logic       saturate;
    logic       load;
    logic [3:0] load_val;
    logic       clr_flags;
    logic [3:0] count;
    logic       at_max;
    logic       at_zero;
    logic       ovf_pulse;
    logic       unf_pulse;
    logic       ovf_sticky;
    logic       unf_sticky;

    int checks = 0;
    int fails  = 0;

    int m_count;
    int m_ovf_p;
    int m_unf_p;
    int m_ovf_s;
    int m_unf_s;

    up_down_counter_mod #(.WIDTH(4), .RESET_VAL(0)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .up_down(up_down), .step(step),
        .limit(limit), .saturate(saturate), .load(load), .load_val(load_val),
        .clr_flags(clr_flags), .count(count), .at_max(at_max), .at_zero(at_zero),
        .ovf_pulse(ovf_pulse), .unf_pulse(unf_pulse), .ovf_sticky(ovf_sticky),
        .unf_sticky(unf_sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_count = 0; m_ovf_p = 0; m_unf_p = 0; m_ovf_s = 0; m_unf_s = 0;
    endtask

    // Reference: plain integer arithmetic on the rules, modulus = limit+1.
    task automatic model_edge();
        int c, lim, m, s;
        c = m_count; lim = int'(limit); m = lim + 1;
        s = (int'(step) > m) ? m : int'(step);
        m_ovf_p = 0; m_unf_p = 0;
        if (load) begin
            c = (int'(load_val) > lim) ? lim : int'(load_val);
        end else if (en) begin
            if (c > lim) begin
                c = 0; m_ovf_p = 1;
            end else if (up_down) begin
                if (c + s > lim) begin
                    m_ovf_p = 1;
                    c = saturate ? lim : (c + s) % m;
                end else c = c + s;
            end else begin
                if (c < s) begin
                    m_unf_p = 1;
                    c = saturate ? 0 : (c - s + m) % m;
                end else c = c - s;
            end
        end
        m_ovf_s = (clr_flags ? 0 : m_ovf_s) | m_ovf_p;
        m_unf_s = (clr_flags ? 0 : m_unf_s) | m_unf_p;
        m_count = c;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".count"},      32'(count),      32'(m_count));
        check({tag, ".at_max"},     32'(at_max),     32'(m_count == int'(limit)));
        check({tag, ".at_zero"},    32'(at_zero),    32'(m_count == 0));
        check({tag, ".ovf_pulse"},  32'(ovf_pulse),  32'(m_ovf_p));
        check({tag, ".unf_pulse"},  32'(unf_pulse),  32'(m_unf_p));
        check({tag, ".ovf_sticky"}, 32'(ovf_sticky), 32'(m_ovf_s));
        check({tag, ".unf_sticky"}, 32'(unf_sticky), 32'(m_unf_s));
    endtask

    // Inputs set before the call are sampled at the next rising edge; outputs checked 1 time unit later.
    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        en = 0; load = 0; clr_flags = 0;
    endtask

    task automatic do_load(input int v);
        load = 1; load_val = 4'(v); en = 0; clr_flags = 0;
        tick("load");
        load = 0;
    endtask

    initial begin
        reset_n = 0; en = 0; up_down = 1; step = 1; limit = 15; saturate = 0;
        load = 0; load_val = 0; clr_flags = 0;
        model_reset();
        #12;
        check_all("reset");
        reset_n = 1;

        // Async reset mid-count: build count=7 with ovf_sticky set.
        do_load(14);
        en = 1; up_down = 1; step = 4;
        tick("pre_rst_ovf");
        do_load(7);
        check("pre_rst.count", 32'(count), 32'd7);
        check("pre_rst.ovf_sticky", 32'(ovf_sticky), 32'd1);
        #2;
        reset_n = 0;
        model_reset();
        #1;
        check("async_rst.count", 32'(count), 32'd0);
        check("async_rst.ovf_sticky", 32'(ovf_sticky), 32'd0);
        en = 1; up_down = 1; step = 1;
        #1;
        reset_n = 1;
        tick("post_rst");
        check("post_rst.first_inc", 32'(count), 32'd1);

        // Wrap up with limit 9.
        limit = 9; saturate = 0;
        do_load(8);
        en = 1; up_down = 1; step = 1;
        tick("wrap_up_9");
        check("wrap_up.at_max", 32'(at_max), 32'd1);
        tick("wrap_up_0");
        check("wrap_up.to0", 32'(count), 32'd0);
        check("wrap_up.ovf", 32'(ovf_pulse), 32'd1);
        tick("wrap_up_1");
        check("wrap_up.ovf_clr", 32'(ovf_pulse), 32'd0);

        // Step-3 wrap down.
        do_load(1);
        en = 1; up_down = 0; step = 3;
        tick("dn3_8");
        check("dn3.to8", 32'(count), 32'd8);
        tick("dn3_5");
        tick("dn3_2");
        tick("dn3_9");
        check("dn3.to9", 32'(count), 32'd9);
        check("dn3.unf", 32'(unf_pulse), 32'd1);
        limit = 15; step = 1;
        do_load(0);
        en = 1; up_down = 0;
        tick("full_dn");
        check("full_dn.to15", 32'(count), 32'd15);

        // Saturate.
        saturate = 1; limit = 15;
        do_load(13);
        en = 1; up_down = 1; step = 4;
        tick("sat_up_a");
        tick("sat_up_b");
        check("sat_up.hold15", 32'(count), 32'd15);
        check("sat_up.ovf_again", 32'(ovf_pulse), 32'd1);
        up_down = 0;
        for (int i = 0; i < 4; i++) tick("sat_dn");
        check("sat_dn.to0", 32'(count), 32'd0);
        check("sat_dn.unf", 32'(unf_pulse), 32'd1);
        saturate = 0;

        // Load priority over enable, clipped to limit; step 0 holds.
        limit = 9; en = 1; load = 1; load_val = 12;
        tick("ld_clip");
        check("ld_clip.count", 32'(count), 32'd9);
        load_val = 5;
        tick("ld_5");
        load = 0; step = 0; en = 1;
        tick("step0_hold");
        check("step0.count", 32'(count), 32'd5);

        // Runtime limit drop, flag clear vs set.
        idle(); clr_flags = 1;
        tick("clr_pre");
        limit = 15;
        do_load(12);
        limit = 7; en = 1; up_down = 1; step = 1; clr_flags = 1;
        tick("lim_drop");
        check("lim_drop.count", 32'(count), 32'd0);
        check("lim_drop.sticky_set_wins", 32'(ovf_sticky), 32'd1);
        en = 0; clr_flags = 1;
        tick("clr_only");
        check("clr_only.sticky", 32'(ovf_sticky), 32'd0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            en        = ($urandom_range(0, 9) != 0);
            up_down   = 1'($urandom);
            step      = 4'($urandom);
            limit     = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
            saturate  = 1'($urandom);
            load      = ($urandom_range(0, 11) == 0);
            load_val  = 4'($urandom);
            clr_flags = ($urandom_range(0, 7) == 0);
            tick("rand");
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/up_down_counter_mod.md
Name: up_down_counter_mod

Overview:
Parametrised successor to the team's 4-bit up/down counter. Adds a runtime modulo limit, programmable step, wrap or saturate mode, synchronous load and count enable. Adds overflow/underflow event pulses and sticky flags. Used as a general-purpose event/position counter in datapath and control blocks.

Parameters:
WIDTH, 4, counter width in bits (>=2).
RESET_VAL, 0, value of count after reset (must be < 2**WIDTH).

Ports:
clk  input  1  rising-edge clock.
reset_n  input  1  asynchronous active-low reset.
en  input  1  count enable; one step per enabled cycle.
up_down  input  1  1 = count up, 0 = count down.
step  input  WIDTH  increment/decrement magnitude; 0 = hold.
limit  input  WIDTH  maximum count value (modulus = limit+1).
saturate  input  1  1 = clip at 0/limit, 0 = modulo wrap.
load  input  1  synchronous load strobe.
load_val  input  WIDTH  value to load.
clr_flags  input  1  clears sticky flags.
count  output  WIDTH  current count (registered).
at_max  output  1  combinational: count == limit.
at_zero  output  1  combinational: count == 0.
ovf_pulse  output  1  registered, 1 cycle: last update overflowed or clipped high.
unf_pulse  output  1  registered, 1 cycle: last update underflowed or clipped low.
ovf_sticky  output  1  set by overflow event, held until cleared.
unf_sticky  output  1  set by underflow event, held until cleared.

Behaviour:
- Reset (reset_n low, async, any time, including mid-count): count=RESET_VAL, ovf_pulse=unf_pulse=0, ovf_sticky=unf_sticky=0. Release is synchronised by the user; the first update occurs on the first rising edge with reset_n high.
- Priority per edge: load > en > hold. Pulses default to 0 each cycle.
- Load: count <= min(load_val, limit). No pulse and no flag change.
- Arithmetic uses WIDTH+1 bits internally, so limit = all-ones (modulus 2**WIDTH) is exact. Effective step s = min(step, limit+1).
- Enabled with count > limit (limit lowered at runtime): count <= 0; ovf_pulse=1 in either direction, in either mode.
- Enabled, up, count <= limit:
  - No overflow (count + s <= limit): count <= count + s.
  - Overflow, wrap mode: count <= count + s - (limit+1); ovf_pulse=1.
  - Overflow, saturate mode: count <= limit; ovf_pulse=1, including when count is already at limit and s > 0.
- Enabled, down, count <= limit:
  - No underflow (count >= s): count <= count - s.
  - Underflow, wrap mode: count <= count + (limit+1) - s; unf_pulse=1.
  - Underflow, saturate mode: count <= 0; unf_pulse=1.
- s=0 with en: count holds, no pulse.
- Stickies: next = (sticky & ~clr_flags) | pulse_event_this_edge. Set wins over clr_flags in the same cycle.
- Latency: count, pulses and stickies reflect inputs sampled at edge N in the cycle after edge N. at_max and at_zero follow count combinationally, using the current limit.
- Mode, limit and step may change on any cycle and take effect at the next edge; no internal state depends on their history.

Test Plan:
- Async reset: WIDTH=4, count=7, ovf_sticky=1; drop reset_n between edges -> count=0 and stickies=0 immediately, no clock needed. Hold en=1 through release -> first increment on the first edge after release.
- Wrap up: limit=9, step=1, up, wrap, start 8 -> 9 (at_max=1) -> 0 with ovf_pulse=1 for 1 cycle, ovf_sticky=1. Then 0 -> 1 with ovf_pulse=0.
- Step wrap down: limit=9, step=3, down, wrap, start 1 -> 8 with unf_pulse=1 -> 5 -> 2 -> 9 with unf_pulse=1. Full range: limit=15, step=1, down, start 0 -> 15 with unf_pulse=1.
- Saturate: saturate=1, limit=15, step=4, up, start 13 -> 15 with ovf_pulse=1 -> 15 with ovf_pulse=1 again. Then down: 15 -> 11 -> 7 -> 3 -> 0 with unf_pulse=1.
- Load priority: load=1, en=1, limit=9, load_val=12 -> count=9, no pulse. load_val=5 -> count=5. step=0, en=1 -> count holds at 5.
- Runtime limit drop and flag clear: count=12, limit changed 15->7, en=1, up -> count=0, ovf_pulse=1. Same cycle clr_flags=1 -> ovf_sticky stays 1. Next cycle clr_flags=1 with no event -> ovf_sticky=0.
